// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit beside ID: tracks in-flight destination
// registers for DEPTH stages, picks the youngest forwarding source and stalls when not ready.
module fwd_hazard_unit #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SEL_W   = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_valid_i,
    input  logic                       issue_wr_i,
    input  logic [REG_W-1:0]           issue_rd_i,
    input  logic [SEL_W-1:0]           issue_lat_i,
    input  logic                       flush_i,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    input  logic [NUM_SRC*REG_W-1:0]   src_reg_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       stall_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    // Index s-1 holds tracker stage s.
    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0][REG_W-1:0]  r_rd;
    logic [DEPTH-1:0][SEL_W-1:0]  r_lat;
    logic [CNT_W-1:0]             r_cnt;

    logic                         w_load_v;
    logic [SEL_W-1:0]             w_lat_clamp;
    logic [NUM_SRC*SEL_W-1:0]     w_sel;
    logic [NUM_SRC-1:0]           w_hazard;
    logic                         w_stall;
    logic [REG_W-1:0]             w_src;
    logic                         w_found;
    logic [SEL_W-1:0]             w_stage;
    logic [SEL_W-1:0]             w_match_lat;

    // Latency is kept within 1..DEPTH so every hazard resolves inside the tracker.
    always_comb begin
        w_lat_clamp = issue_lat_i;
        if (issue_lat_i == '0) begin
            w_lat_clamp = SEL_W'(1);
        end else if (32'(issue_lat_i) > DEPTH) begin
            w_lat_clamp = SEL_W'(DEPTH);
        end
    end

    assign w_load_v = issue_valid_i & issue_wr_i & (issue_rd_i != '0) & ~w_stall & ~flush_i;

    // Per-source lookup; scanning oldest to youngest lets the youngest match win.
    always_comb begin
        w_sel       = '0;
        w_hazard    = '0;
        w_src       = '0;
        w_found     = 1'b0;
        w_stage     = '0;
        w_match_lat = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_src       = src_reg_i[i*REG_W +: REG_W];
            w_found     = 1'b0;
            w_stage     = '0;
            w_match_lat = '0;
            if (src_valid_i[i] && (w_src != '0)) begin
                for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
                    if (r_v[s] && (r_rd[s] == w_src)) begin
                        w_found     = 1'b1;
                        w_stage     = SEL_W'(s + 1);
                        w_match_lat = r_lat[s];
                    end
                end
            end
            if (w_found) begin
                if (w_stage >= w_match_lat) begin
                    w_sel[i*SEL_W +: SEL_W] = w_stage;
                end else begin
                    w_hazard[i] = 1'b1;
                end
            end
        end
    end

    assign w_stall     = (|w_hazard) & ~flush_i;
    assign fwd_sel_o   = w_sel;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_cnt;

    // Tracker shifts every cycle, stalls included, so bubbles drain hazards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v   <= '0;
            r_rd  <= '0;
            r_lat <= '0;
        end else begin
            for (int s = int'(DEPTH) - 1; s > 0; s--) begin
                r_v[s]   <= r_v[s-1];
                r_rd[s]  <= r_rd[s-1];
                r_lat[s] <= r_lat[s-1];
            end
            r_v[0]   <= w_load_v;
            r_rd[0]  <= issue_rd_i;
            r_lat[0] <= w_lat_clamp;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an issue-history reference model.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     issue_valid_i;
    logic                     issue_wr_i;
    logic [REG_W-1:0]         issue_rd_i;
    logic [SEL_W-1:0]         issue_lat_i;
    logic                     flush_i;
    logic [NUM_SRC-1:0]       src_valid_i;
    logic [NUM_SRC*REG_W-1:0] src_reg_i;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
    logic                     stall_o;
    logic [CNT_W-1:0]         stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_unit #(
        .REG_W(REG_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_wr_i(issue_wr_i),
        .issue_rd_i(issue_rd_i), .issue_lat_i(issue_lat_i),
        .flush_i(flush_i), .src_valid_i(src_valid_i), .src_reg_i(src_reg_i),
        .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sel_of(input int i);
        return int'(fwd_sel_o[i*SEL_W +: SEL_W]);
    endfunction

    // Reference model: a history of accepted issues tagged with the clock edge that
    // captured them; an entry's stage is simply its age in edges.
    int  q_rd[$];
    int  q_lat[$];
    int  q_edge[$];
    int  edge_cnt = 0;
    int  m_cnt = 0;
    bit  ready = 1'b0;

    initial begin : model
        bit m_rst, m_v, m_wr, m_flush, exp_stall, any_haz;
        int m_rd, m_lat, exp_sel, src, stg;
        forever begin
            @(negedge clk_i);
            m_rst = rst_i; m_v = issue_valid_i; m_wr = issue_wr_i;
            m_rd = int'(issue_rd_i); m_lat = int'(issue_lat_i); m_flush = flush_i;
            while (q_edge.size() > 0 && (edge_cnt - q_edge[0] + 1) > int'(DEPTH)) begin
                void'(q_rd.pop_front()); void'(q_lat.pop_front()); void'(q_edge.pop_front());
            end
            any_haz = 1'b0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                exp_sel = 0;
                src = int'(src_reg_i[i*REG_W +: REG_W]);
                if (src_valid_i[i] && src != 0) begin
                    for (int j = q_rd.size() - 1; j >= 0; j--) begin
                        if (q_rd[j] == src) begin
                            stg = edge_cnt - q_edge[j] + 1;
                            if (stg >= q_lat[j]) exp_sel = stg;
                            else any_haz = 1'b1;
                            break;
                        end
                    end
                end
                if (ready) chk($sformatf("model_sel%0d", i), sel_of(i), exp_sel);
            end
            exp_stall = any_haz && !m_flush;
            if (ready) begin
                chk("model_stall", int'(stall_o), int'(exp_stall));
                chk("model_cnt", int'(stall_cnt_o), m_cnt);
            end
            @(posedge clk_i);
            edge_cnt++;
            if (m_rst) begin
                q_rd.delete(); q_lat.delete(); q_edge.delete();
                m_cnt = 0;
                ready = 1'b1;
            end else if (ready) begin
                if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
                if (!exp_stall && !m_flush && m_v && m_wr && m_rd != 0) begin
                    q_rd.push_back(m_rd);
                    q_lat.push_back(m_lat == 0 ? 1 : (m_lat > int'(DEPTH) ? int'(DEPTH) : m_lat));
                    q_edge.push_back(edge_cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic issue(input bit v, input int rd, input int lat);
        issue_valid_i = v;
        issue_wr_i    = v;
        issue_rd_i    = REG_W'(rd);
        issue_lat_i   = SEL_W'(lat);
    endtask

    task automatic set_src(input int i, input bit v, input int r);
        src_valid_i[i] = v;
        src_reg_i[i*REG_W +: REG_W] = REG_W'(r);
    endtask

    task automatic clear_src();
        src_valid_i = '0;
        src_reg_i   = '0;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        issue(0, 0, 0);
        clear_src();
        repeat (2) tick();
        rst_i = 1'b0;
        at_neg();
        chk("reset_sel0", sel_of(0), 0);
        chk("reset_stall", int'(stall_o), 0);
        chk("reset_cnt", int'(stall_cnt_o), 0);
        tick();

        // ALU chain
        issue(1, 5, 1); tick();
        issue(0, 0, 0); set_src(0, 1, 5);
        at_neg(); chk("alu_sel_s1", sel_of(0), 1); chk("alu_stall", int'(stall_o), 0);
        tick(); at_neg(); chk("alu_sel_s2", sel_of(0), 2);
        tick(); at_neg(); chk("alu_sel_s3", sel_of(0), 3);
        tick(); at_neg(); chk("alu_sel_retired", sel_of(0), 0);
        clear_src(); tick();

        // Load-use
        issue(1, 8, 2); tick();
        issue(0, 0, 0); set_src(1, 1, 8);
        at_neg(); chk("lu_stall", int'(stall_o), 1); chk("lu_sel1_stall", sel_of(1), 0);
        tick(); at_neg();
        chk("lu_sel1_after", sel_of(1), 2); chk("lu_stall_after", int'(stall_o), 0);
        chk("lu_cnt", int'(stall_cnt_o), 1);
        clear_src(); tick();

        // Youngest wins
        issue(1, 3, 1); tick(); tick();
        issue(0, 0, 0); set_src(0, 1, 3); set_src(1, 1, 3);
        at_neg(); chk("young_sel0", sel_of(0), 1); chk("young_sel1", sel_of(1), 1);
        clear_src(); tick();

        // Register zero and invalid source
        issue(1, 0, 2); tick();
        issue(0, 0, 0); set_src(0, 1, 0);
        at_neg(); chk("zero_sel0", sel_of(0), 0); chk("zero_stall", int'(stall_o), 0);
        clear_src(); tick();
        issue(1, 9, 2); tick();
        issue(0, 0, 0); set_src(0, 0, 9);
        at_neg(); chk("inval_sel0", sel_of(0), 0); chk("inval_stall", int'(stall_o), 0);
        clear_src(); tick();

        // Flush
        issue(1, 7, 1); flush_i = 1'b1; tick();
        issue(0, 0, 0); flush_i = 1'b0; set_src(0, 1, 7);
        at_neg(); chk("flush_sel0", sel_of(0), 0);
        clear_src(); tick();
        issue(1, 10, 2); tick();
        issue(0, 0, 0); set_src(0, 1, 10); flush_i = 1'b1;
        at_neg(); chk("flush_haz_stall", int'(stall_o), 0); chk("flush_haz_cnt", int'(stall_cnt_o), 1);
        tick(); flush_i = 1'b0; clear_src();
        at_neg(); chk("flush_haz_cnt_after", int'(stall_cnt_o), 1);
        tick();

        // Saturation
        repeat (20) begin
            issue(1, 12, 2); tick();
            issue(0, 0, 0); set_src(0, 1, 12); tick();
            clear_src(); tick();
        end
        at_neg(); chk("sat_cnt", int'(stall_cnt_o), CNT_MAX);

        // Reset mid-stream
        issue(1, 12, 1); tick();
        issue(0, 0, 0); rst_i = 1'b1; tick();
        rst_i = 1'b0; set_src(0, 1, 12);
        at_neg(); chk("rst_sel0", sel_of(0), 0); chk("rst_cnt", int'(stall_cnt_o), 0);
        clear_src(); tick();

        // Randomized traffic, checked by the model
        for (int c = 0; c < 3000; c++) begin
            rst_i         = ($urandom_range(0, 299) == 0);
            issue_valid_i = ($urandom_range(0, 3) != 0);
            issue_wr_i    = ($urandom_range(0, 4) != 0);
            issue_rd_i    = REG_W'($urandom_range(0, 7));
            issue_lat_i   = SEL_W'($urandom_range(0, 3));
            flush_i       = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < int'(NUM_SRC); i++)
                set_src(i, bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
            tick();
        end
        rst_i = 1'b0; issue(0, 0, 0); clear_src(); flush_i = 1'b0;
        tick(); at_neg(); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
